// File: rtl/shift_op_pkg.sv
// shift_op_pkg: op and state encodings shared by the shift sequencer
package shift_op_pkg;
  localparam logic [1:0] OP_ROR  = 2'b00;
  localparam logic [1:0] OP_ROL  = 2'b01;
  localparam logic [1:0] OP_ASR  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
endpackage

// File: rtl/shift_down_counter.sv
// shift_down_counter: loadable down-counter that stops at zero
module shift_down_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] value,
  output logic [CNT_W-1:0] count,
  output logic             zero
);
  assign zero = count == '0;
  // load has priority; decrement saturates at zero so the count never wraps
  always_ff @(posedge clock or posedge reset)
    if (reset) count <= '0;
    else if (load) count <= value;
    else if (dec && !zero) count <= count - CNT_W'(1);
endmodule

// File: rtl/shift_op_controller.sv
// shift_op_controller: loads an operand into the rotating register, then issues the requested shifts
module shift_op_controller
  import shift_op_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [CNT_W-1:0] amount,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] q_in,
  output logic             busy,
  output logic             done,
  output logic             ParallelLoadn,
  output logic             RotateRight,
  output logic             ASRight,
  output logic [WIDTH-1:0] Data_IN
);
  logic [1:0]       state, state_nx, op_q;
  logic [WIDTH-1:0] operand_q;
  logic [CNT_W-1:0] amount_q, count;
  logic             zero, shifting;
  assign shifting = state == S_SHIFT;
  shift_down_counter #(.CNT_W(CNT_W)) u_cnt (
    .clock(clock),
    .reset(reset),
    .load (state == S_LOAD),
    .dec  (shifting),
    .value(amount_q),
    .count(count),
    .zero (zero)
  );
  // load-only or zero-amount commands skip SHIFT; the last shift edge is the one seeing count==1
  always_comb
    state_nx = state == S_IDLE  ? (start ? S_LOAD : S_IDLE)
             : state == S_LOAD  ? ((op_q != OP_LOAD && amount_q != '0) ? S_SHIFT : S_DONE)
             : state == S_SHIFT ? ((count == CNT_W'(1) || zero) ? S_DONE : S_SHIFT)
             : S_IDLE;
  // state register and command capture on the accepting edge
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state     <= S_IDLE;
      op_q      <= '0;
      amount_q  <= '0;
      operand_q <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && start) begin
        op_q      <= op;
        amount_q  <= amount;
        operand_q <= data_in;
      end
    end
  assign busy          = state == S_LOAD || shifting;
  assign done          = state == S_DONE;
  assign ParallelLoadn = shifting;
  assign RotateRight   = shifting && (op_q == OP_ROR || op_q == OP_ASR);
  assign ASRight       = shifting && op_q == OP_ASR;
  assign Data_IN       = state == S_LOAD ? operand_q : q_in;
endmodule

// File: tb/tb_shift_op_controller.sv
// tb_shift_op_controller: drives the sequencer against a rotating register and checks it against a command-level model
module tb_shift_op_controller;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [1:0] op = 2'd0;
  logic [2:0] amount = 3'd0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] q = 8'h00;
  logic       busy, done, pl_n, rr, asr;
  logic [7:0] din_reg;
  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int t0 = 0;
  int n = 0;
  bit pend = 1'b0;
  logic [1:0] op_m = 2'd0;
  logic [7:0] d_m = 8'h00;
  logic [7:0] exp_res = 8'h00;
  logic [7:0] hold_val = 8'h00;

  shift_op_controller #(.WIDTH(8), .CNT_W(3)) dut (
    .clock(clk),
    .reset(rst),
    .start(start),
    .op(op),
    .amount(amount),
    .data_in(data_in),
    .q_in(q),
    .busy(busy),
    .done(done),
    .ParallelLoadn(pl_n),
    .RotateRight(rr),
    .ASRight(asr),
    .Data_IN(din_reg)
  );

  always #5 clk = ~clk;

  // the 8-bit rotating register: load when ParallelLoadn=0, otherwise shift every clock
  always @(posedge clk)
    q <= !pl_n ? din_reg : rr ? {asr ? q[7] : q[0], q[7:1]} : {q[6:0], q[7]};

  function automatic logic [7:0] apply(input logic [1:0] o, input logic [7:0] d, input int k);
    logic [15:0] w;
    w = {d, d};
    return o == 2'd0 ? 8'(w >> k)
         : o == 2'd1 ? 8'((w << k) >> 8)
         : o == 2'd2 ? 8'($signed(d) >>> k)
         : d;
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    else pass_cnt++;
  endtask

  // command-level model: accept when no command is in flight, result known at accept time
  always @(posedge clk or posedge rst)
    if (rst) begin
      if (pend && cyc >= t0 + 1 && cyc <= t0 + 1 + n) hold_val = apply(op_m, d_m, cyc - t0 - 1);
      pend = 1'b0;
    end else begin
      if (start && !(pend && cyc >= t0 && cyc <= t0 + 1 + n)) begin
        pend = 1'b1;
        t0 = cyc + 1;
        op_m = op;
        d_m = data_in;
        n = op == 2'd3 ? 0 : int'(amount);
        exp_res = apply(op, data_in, n);
      end
      cyc = cyc + 1;
      if (pend && cyc == t0 + 1 + n) hold_val = exp_res;
    end

  // per-cycle comparison of handshake, register control and register contents
  always @(negedge clk)
    if (!rst) begin : cmp
      int c;
      logic [7:0] eq;
      c = cyc;
      eq = (pend && c >= t0 + 1 && c <= t0 + 1 + n) ? apply(op_m, d_m, c - t0 - 1) : hold_val;
      check("busy", busy, pend && c >= t0 && c <= t0 + n);
      check("done", done, pend && c == t0 + 1 + n);
      check("pl_n", pl_n, pend && c >= t0 + 1 && c <= t0 + n);
      check("q", q, eq);
    end

  task automatic run(input logic [7:0] d, input logic [1:0] o, input logic [2:0] a,
                     input logic [7:0] exp, input int edges);
    int k;
    @(negedge clk);
    data_in = d; op = o; amount = a; start = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      data_in = 8'($urandom); op = 2'($urandom); amount = 3'($urandom);
      k++;
    end while (!done && k < 20);
    check("done_edges", k, edges);
    check("result", q, exp);
    check("busy_on_done", busy, 1'b0);
  endtask

  initial begin : stim
    int dcount;
    logic [7:0] qd;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pl_n", pl_n, 1'b0);
    check("rst_rr", rr, 1'b0);
    check("rst_asr", asr, 1'b0);
    check("rst_data", din_reg, 8'h00);
    #2 rst = 1'b0;
    run(8'h81, 2'b00, 3'd1, 8'hC0, 3);
    run(8'h81, 2'b01, 3'd3, 8'h0C, 5);
    repeat (5) begin
      @(negedge clk);
      check("idle_hold", q, 8'h0C);
    end
    run(8'h90, 2'b10, 3'd3, 8'hF2, 5);
    run(8'h80, 2'b10, 3'd7, 8'hFF, 9);
    run(8'hA5, 2'b00, 3'd0, 8'hA5, 2);
    run(8'h3C, 2'b11, 3'd5, 8'h3C, 2);
    run(8'hA5, 2'b11, 3'd5, 8'hA5, 2);
    @(negedge clk);
    data_in = 8'h81; op = 2'b00; amount = 3'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    data_in = 8'h11; op = 2'b11; amount = 3'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dcount = 0;
    qd = 8'h00;
    repeat (10) begin
      @(negedge clk);
      if (done) begin
        dcount++;
        qd = q;
      end
    end
    check("ignored_start_dones", dcount, 1);
    check("ignored_start_result", qd, 8'h0C);
    @(negedge clk);
    data_in = 8'h81; op = 2'b01; amount = 3'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_pl_n", pl_n, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_q", q, 8'h03);
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("abort_no_done", done, 1'b0);
      check("abort_hold", q, 8'h03);
    end
    run(8'h3C, 2'b10, 3'd2, 8'h0F, 4);
    run(8'h81, 2'b00, 3'd7, 8'h03, 9);
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
